bn_channel_sequencer: RTL and testbench

Controller that sequences a channel-major feature-map stream into the runtime-coefficient batchnorm scale/shift stage. It holds a per-channel GAMMA/BETA table written over a config port. It counts pixels and channels, and tags every accepted beat with the coefficients for its channel. It sits between the conv output stream and the scale/shift datapath and reports frame completion to the layer controller.

---
 rtl/bn_channel_sequencer.sv | 136 +++++++++++++
 tb/tb_bn_channel_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bn_channel_sequencer.sv
// Channel-major stream sequencer for the batchnorm scale/shift stage: counts pixels and
// channels and tags each accepted beat with that channel's gamma/beta from a writable table.
//
// state | meaning
// IDLE  | waiting for start; coefficient table writable
// RUN   | accepting beats, counting pixels/channels
// DONE  | one-cycle frame-complete pulse
module bn_channel_sequencer #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int FRAC     = 4,
  parameter int CHANNELS = 4,
  parameter int PIXELS   = 16,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int PIX_W    = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic                     cfg_sel,
  input  logic [CH_W-1:0]          cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_wdata,
  output logic                     cfg_err,
  input  logic                     start,
  input  logic                     abort,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] ss_data,
  output logic signed [COEF_W-1:0] ss_gamma,
  output logic signed [COEF_W-1:0] ss_beta,
  output logic [CH_W-1:0]          ss_ch,
  output logic                     ss_valid,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CH_W-1:0]          CH_LAST   = CH_W'(CHANNELS - 1);
  localparam logic [PIX_W-1:0]         PIX_LAST  = PIX_W'(PIXELS - 1);
  localparam logic signed [COEF_W-1:0] GAMMA_ONE = COEF_W'(1 << FRAC);

  state_t state, state_nxt;

  logic signed [COEF_W-1:0] gamma_tbl [CHANNELS];
  logic signed [COEF_W-1:0] beta_tbl  [CHANNELS];

  logic [PIX_W-1:0] pix_cnt;
  logic [CH_W-1:0]  ch_cnt;
  logic             accept;
  logic             take;
  logic             last_beat;
  logic             cfg_ok;

  assign accept    = in_valid && (state == RUN);
  // abort wins over a beat offered in the same cycle
  assign take      = accept && !abort;
  assign last_beat = (ch_cnt == CH_LAST) && (pix_cnt == PIX_LAST);
  assign cfg_ok    = (state == IDLE) && (int'(cfg_addr) < CHANNELS);

  assign busy     = (state == RUN);
  assign in_ready = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort)                  state_nxt = IDLE;
        else if (take && last_beat) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      ch_cnt  <= '0;
    end else if (state == IDLE && start) begin
      pix_cnt <= '0;
      ch_cnt  <= '0;
    end else if (take) begin
      if (pix_cnt == PIX_LAST) begin
        pix_cnt <= '0;
        ch_cnt  <= (ch_cnt == CH_LAST) ? '0 : ch_cnt + 1'b1;
      end else begin
        pix_cnt <= pix_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_data  <= '0;
      ss_gamma <= '0;
      ss_beta  <= '0;
      ss_ch    <= '0;
      ss_valid <= 1'b0;
    end else begin
      ss_valid <= take;
      if (take) begin
        ss_data  <= in_data;
        ss_gamma <= gamma_tbl[ch_cnt];
        ss_beta  <= beta_tbl[ch_cnt];
        ss_ch    <= ch_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        gamma_tbl[i] <= GAMMA_ONE;
        beta_tbl[i]  <= '0;
      end
    end else if (cfg_we && cfg_ok) begin
      if (cfg_sel) beta_tbl[cfg_addr]  <= cfg_wdata;
      else         gamma_tbl[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= cfg_we && !cfg_ok;
  end

endmodule

// File: tb/tb_bn_channel_sequencer.sv
// Directed bench for bn_channel_sequencer: a 4x16 instance for framing/coefficients and a
// 5x2 instance whose 3-bit address can reach past the table.
module tb_bn_channel_sequencer;

  localparam int NB = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_we = 0, cfg_sel = 0, cfg_err;
  logic [1:0]        cfg_addr = '0;
  logic signed [7:0] cfg_wdata = '0;
  logic              start = 0, abort = 0, in_valid = 0, in_ready;
  logic signed [7:0] in_data = '0, ss_data, ss_gamma, ss_beta;
  logic [1:0]        ss_ch;
  logic              ss_valid, busy, done;

  logic              o_cfg_we = 0, o_cfg_sel = 0, o_cfg_err;
  logic [2:0]        o_cfg_addr = '0;
  logic signed [7:0] o_cfg_wdata = '0;
  logic              o_start = 0, o_abort = 0, o_in_valid = 0, o_in_ready;
  logic signed [7:0] o_in_data = '0, o_ss_data, o_ss_gamma, o_ss_beta;
  logic [2:0]        o_ss_ch;
  logic              o_ss_valid, o_busy, o_done;

  bn_channel_sequencer #(.CHANNELS(4), .PIXELS(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .ss_data(ss_data),
    .ss_gamma(ss_gamma), .ss_beta(ss_beta), .ss_ch(ss_ch), .ss_valid(ss_valid),
    .busy(busy), .done(done));

  bn_channel_sequencer #(.CHANNELS(5), .PIXELS(2)) u_odd (
    .clk(clk), .rst_n(rst_n), .cfg_we(o_cfg_we), .cfg_sel(o_cfg_sel), .cfg_addr(o_cfg_addr),
    .cfg_wdata(o_cfg_wdata), .cfg_err(o_cfg_err), .start(o_start), .abort(o_abort),
    .in_data(o_in_data), .in_valid(o_in_valid), .in_ready(o_in_ready), .ss_data(o_ss_data),
    .ss_gamma(o_ss_gamma), .ss_beta(o_ss_beta), .ss_ch(o_ss_ch), .ss_valid(o_ss_valid),
    .busy(o_busy), .done(o_done));

  int n_chk = 0;
  int n_pass = 0;
  int exp_g [4];
  int exp_b [4];

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic cfg_write(input logic sel, input logic [1:0] addr, input int val);
    cfg_we = 1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = 8'(val);
    @(negedge clk);
    check("cfg_err_idle_write", int'(cfg_err), 0);
    cfg_we = 0;
  endtask

  // gap: in_valid pattern 1,0,0,1; rw_at: rejected gamma[0]=64 write at that beat count;
  // abort_at: abort together with a valid beat once that many beats are accepted
  task automatic run_frame(input bit gap, input int rw_at, input int abort_at);
    int acc, cyc, idx, beat_data;
    bit took, fin, wrote;
    acc = 0; cyc = 0; fin = 0; wrote = 0;
    start = 1;
    @(negedge clk);
    start = 0; cfg_we = 0;
    check("busy_after_start", int'(busy), 1);
    check("cfg_err_after_start", int'(cfg_err), 0);
    while (!fin && cyc < 1000) begin
      in_valid = gap ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      cfg_we = 0;
      if (rw_at >= 0 && acc == rw_at && !wrote) begin
        cfg_we = 1; cfg_sel = 0; cfg_addr = 2'd0; cfg_wdata = 8'sd64; wrote = 1;
      end
      abort = (abort_at >= 0 && acc == abort_at && in_valid);
      check("in_ready_run", int'(in_ready), 1);
      took = in_valid && !abort;
      beat_data = int'(in_data);
      idx = acc;
      @(negedge clk);
      cyc++;
      check("ss_valid", int'(ss_valid), int'(took));
      if (took) begin
        check("ss_data", int'(ss_data), beat_data);
        check("ss_ch", int'(ss_ch), idx / 16);
        check("ss_gamma", int'(ss_gamma), exp_g[idx / 16]);
        check("ss_beta", int'(ss_beta), exp_b[idx / 16]);
        acc++;
      end
      check("cfg_err_run", int'(cfg_err), int'(cfg_we));
      if (abort) begin
        check("abort_busy", int'(busy), 0);
        check("abort_in_ready", int'(in_ready), 0);
        check("abort_done", int'(done), 0);
        fin = 1;
      end else if (acc == NB) begin
        check("done_pulse", int'(done), 1);
        check("in_ready_done", int'(in_ready), 0);
        check("busy_done", int'(busy), 0);
        fin = 1;
      end else begin
        check("done_early", int'(done), 0);
        check("busy_run", int'(busy), 1);
      end
    end
    abort = 0; in_valid = 0; cfg_we = 0;
    if (!fin) check("frame_timeout", 0, 1);
    @(negedge clk);
    check("done_after", int'(done), 0);
    check("busy_after", int'(busy), 0);
    check("ss_valid_after", int'(ss_valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ss_valid", int'(ss_valid), 0);
    check("rst_ss_gamma", int'(ss_gamma), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    rst_n = 1;
    @(negedge clk);

    exp_g = '{16, 16, 16, 16};
    exp_b = '{0, 0, 0, 0};
    run_frame(0, -1, -1);

    cfg_write(0, 2'd0, 16);
    cfg_write(0, 2'd1, 32);
    cfg_write(0, 2'd2, 8);
    cfg_write(0, 2'd3, -16);
    cfg_write(1, 2'd0, 0);
    cfg_write(1, 2'd1, 3);
    cfg_write(1, 2'd2, -2);
    cfg_we = 1; cfg_sel = 1; cfg_addr = 2'd3; cfg_wdata = 8'sd7;  // lands with start
    exp_g = '{16, 32, 8, -16};
    exp_b = '{0, 3, -2, 7};
    run_frame(0, -1, -1);

    run_frame(1, -1, -1);
    run_frame(0, 3, -1);

    run_frame(0, -1, 20);
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_abort", int'(done), 0);
    end
    run_frame(0, -1, -1);

    start = 1;
    @(negedge clk);
    start = 0; in_valid = 1;
    repeat (30) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_ss_valid", int'(ss_valid), 0);
    check("arst_ss_data", int'(ss_data), 0);
    check("arst_ss_gamma", int'(ss_gamma), 0);
    check("arst_ss_beta", int'(ss_beta), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_in_ready", int'(in_ready), 0);
    check("arst_done", int'(done), 0);
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    exp_g = '{16, 16, 16, 16};
    exp_b = '{0, 0, 0, 0};
    run_frame(0, -1, -1);

    o_cfg_we = 1; o_cfg_sel = 0; o_cfg_addr = 3'd5; o_cfg_wdata = 8'sd99;
    @(negedge clk);
    o_cfg_we = 0;
    check("odd_addr_err", int'(o_cfg_err), 1);
    @(negedge clk);
    check("odd_err_one_cycle", int'(o_cfg_err), 0);
    o_cfg_we = 1; o_cfg_addr = 3'd4; o_cfg_wdata = 8'sd20;
    @(negedge clk);
    o_cfg_we = 0;
    check("odd_addr4_ok", int'(o_cfg_err), 0);
    o_start = 1;
    @(negedge clk);
    o_start = 0; o_in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      o_in_data = 8'(i + 1);
      @(negedge clk);
      check("odd_ss_valid", int'(o_ss_valid), 1);
      check("odd_ss_data", int'(o_ss_data), i + 1);
      check("odd_ss_ch", int'(o_ss_ch), i / 2);
      check("odd_ss_gamma", int'(o_ss_gamma), (i / 2 == 4) ? 20 : 16);
      check("odd_done", int'(o_done), (i == 9) ? 1 : 0);
    end
    o_in_valid = 0;
    @(negedge clk);
    check("odd_done_after", int'(o_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
